mult_serial_host: RTL and testbench

Host-side companion to the 16x16 serial multiplier core. It accepts a parallel operand pair over a valid/ready request port and serializes both operands onto A_PAD/B_PAD. It then deserializes the two-lane product returned on P0/P1 and presents the 32-bit result on a valid/ready response port. It sits in the user project beside the multiplier core, on the same clock, and is intended for host logic (Wishbone/LA bridge) or a loopback bench.

---
 rtl/mult_serial_pkg.sv | 31 +++
 rtl/mult_serial_shreg.sv | 42 ++++
 rtl/mult_serial_host.sv | 161 ++++++++++++++++
 tb/tb_mult_serial_host.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_serial_pkg.sv
// Shared types and constants for the serial multiplier host: FSM states,
// line levels, shift-register slot indices and counter sizing.
package mult_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT,
    RECV,
    DONE
  } state_t;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;

  // Slots of the four shift-register instances in the host.
  localparam int SH_A   = 0;
  localparam int SH_B   = 1;
  localparam int SH_PL  = 2;
  localparam int SH_PH  = 3;
  localparam int NUM_SH = 4;

  // One counter serves both the bit index and the wait timer.
  function automatic int cnt_width(input int opw, input int timeout);
    int m;
    m = (opw > timeout) ? opw : timeout;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mult_serial_shreg.sv
// Parametric shift register: parallel load, or shift right with a serial bit
// entering at the MSB. TX uses bit 0 as the serial output; RX fills from the top.
module mult_serial_shreg
  import mult_serial_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] data_q
);

  logic [W-1:0] data_reg;
  logic [W-1:0] data_next;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      logic upper;
      if (gi == W - 1) begin : g_msb
        assign upper = shift_in;
      end else begin : g_mid
        assign upper = data_reg[gi+1];
      end
      assign data_next[gi] = load ? load_data[gi] : (shift_en ? upper : data_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  assign data_q = data_reg;

endmodule

// File: rtl/mult_serial_host.sv
// Host side of the serial multiplier link: serializes an operand pair onto
// A_PAD/B_PAD and deserializes the two-lane product from P0/P1.
module mult_serial_host
  import mult_serial_pkg::*;
#(
  parameter int OPW     = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_a,
  input  logic [OPW-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*OPW-1:0] rsp_product,
  output logic             rsp_timeout,
  output logic             A_PAD,
  output logic             B_PAD,
  input  logic             P0,
  input  logic             P1,
  output logic             busy
);

  localparam int CW = cnt_width(OPW, TIMEOUT);
  localparam logic [CW-1:0] LAST_BIT  = CW'(OPW - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          timeout_reg, timeout_next;
  logic          accept;

  logic           sh_load      [NUM_SH];
  logic [OPW-1:0] sh_load_data [NUM_SH];
  logic           sh_shift     [NUM_SH];
  logic           sh_in        [NUM_SH];
  logic [OPW-1:0] sh_q         [NUM_SH];

  generate
    for (genvar gi = 0; gi < NUM_SH; gi++) begin : g_shreg
      mult_serial_shreg #(.W(OPW)) u_shreg (
        .clk       (clk),
        .srst      (rst),
        .load      (sh_load[gi]),
        .load_data (sh_load_data[gi]),
        .shift_en  (sh_shift[gi]),
        .shift_in  (sh_in[gi]),
        .data_q    (sh_q[gi])
      );
    end
  endgenerate

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    for (int i = 0; i < NUM_SH; i++) begin
      sh_load[i]      = 1'b0;
      sh_load_data[i] = '0;
      sh_shift[i]     = 1'b0;
      sh_in[i]        = LINE_IDLE;
    end
    sh_load_data[SH_A] = req_a;
    sh_load_data[SH_B] = req_b;

    case (state_reg)
      IDLE: begin
        // Accepting also clears the product registers so a timeout reads zero.
        if (accept) begin
          state_next   = START;
          timeout_next = 1'b0;
          for (int i = 0; i < NUM_SH; i++) begin
            sh_load[i] = 1'b1;
          end
        end
      end
      START: begin
        state_next = SEND;
        cnt_next   = '0;
      end
      SEND: begin
        sh_shift[SH_A] = 1'b1;
        sh_shift[SH_B] = 1'b1;
        if (cnt_reg == LAST_BIT) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT: begin
        // A start bit on the last wait cycle still counts as a response.
        if (P0 == START_BIT) begin
          state_next = RECV;
          cnt_next   = '0;
        end else if (cnt_reg == LAST_WAIT) begin
          state_next      = DONE;
          timeout_next    = 1'b1;
          sh_load[SH_PL]  = 1'b1;
          sh_load[SH_PH]  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RECV: begin
        sh_shift[SH_PL] = 1'b1;
        sh_shift[SH_PH] = 1'b1;
        sh_in[SH_PL]    = P0;
        sh_in[SH_PH]    = P1;
        if (cnt_reg == LAST_BIT) begin
          state_next   = DONE;
          timeout_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy        = (state_reg != IDLE);
  assign rsp_valid   = (state_reg == DONE);
  assign rsp_timeout = timeout_reg;
  assign rsp_product = {sh_q[SH_PH], sh_q[SH_PL]};

  always_comb begin
    A_PAD = LINE_IDLE;
    B_PAD = LINE_IDLE;
    if (state_reg == START) begin
      A_PAD = START_BIT;
    end else if (state_reg == SEND) begin
      A_PAD = sh_q[SH_A][0];
      B_PAD = sh_q[SH_B][0];
    end
  end

endmodule

// File: tb/tb_mult_serial_host.sv
// Bench for mult_serial_host: a line-level core model answers requests, a
// timing model predicts every output cycle by cycle, directed cases pin it.
module tb_mult_serial_host;

  localparam int OPW     = 16;
  localparam int TIMEOUT = 64;
  localparam int PW      = 2 * OPW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           rsp_ready = 1'b0;
  logic [OPW-1:0] req_a = '0;
  logic [OPW-1:0] req_b = '0;
  logic           P0 = 1'b0;
  logic           P1 = 1'b0;
  logic           req_ready, rsp_valid, rsp_timeout, A_PAD, B_PAD, busy;
  logic [PW-1:0]  rsp_product;

  mult_serial_host #(.OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_timeout (rsp_timeout),
    .A_PAD       (A_PAD),
    .B_PAD       (B_PAD),
    .P0          (P0),
    .P1          (P1),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Core model: decodes the request frame from the pads, then answers a*b
  // core_delay cycles into the wait window (negative: never answers).
  int             core_delay = 0;
  bit             stray_p0 = 1'b0;
  int             c_phase = 0, c_idx = 0, c_dcnt = 0;
  logic [OPW-1:0] c_a, c_b;
  logic [PW-1:0]  c_prod;

  always @(negedge clk) begin
    if (rst) begin
      c_phase = 0;
      P0 = 1'b0;
      P1 = 1'b0;
    end else begin
      case (c_phase)
        0: begin
          P0 = stray_p0; P1 = 1'b0;
          if (A_PAD) begin c_phase = 1; c_idx = 0; end
        end
        1: begin
          P0 = stray_p0; P1 = 1'b0;
          c_a[c_idx] = A_PAD;
          c_b[c_idx] = B_PAD;
          c_idx++;
          if (c_idx == OPW) begin
            c_prod  = PW'(c_a) * PW'(c_b);
            c_dcnt  = 0;
            c_phase = (core_delay < 0) ? 0 : 2;
          end
        end
        2: begin
          P1 = 1'b0;
          if (c_dcnt == core_delay) begin
            P0 = 1'b1; c_idx = 0; c_phase = 3;
          end else begin
            P0 = 1'b0; c_dcnt++;
          end
        end
        default: begin
          if (c_idx == OPW) begin
            P0 = 1'b0; P1 = 1'b0; c_phase = 0;
          end else begin
            P0 = c_prod[c_idx];
            P1 = c_prod[OPW+c_idx];
            c_idx++;
          end
        end
      endcase
    end
  end

  // Reference model: m_active 0 idle, 1 in flight, 2 result offered.
  // m_age is the cycle number after acceptance (1 = start-bit cycle).
  int             m_active = 0, m_age = 0, m_start_age = 0, txn = 0;
  bit             m_got = 1'b0, m_after_rst = 1'b0, m_started = 1'b0;
  logic [OPW-1:0] m_a, m_b;
  logic [PW-1:0]  m_prod = '0;
  logic           m_to = 1'b0;

  always @(posedge clk) begin
    int j;
    if (rst) begin
      m_active    = 0;
      m_after_rst = 1'b1;
      m_started   = 1'b1;
    end else begin
      case (m_active)
        0: if (req_valid) begin
          m_active = 1; m_age = 1; m_a = req_a; m_b = req_b;
          m_got = 1'b0; m_prod = '0; m_to = 1'b0; m_after_rst = 1'b0;
        end
        1: begin
          if (!m_got) begin
            if (m_age >= OPW + 2 && m_age <= OPW + 1 + TIMEOUT && P0) begin
              m_got = 1'b1; m_start_age = m_age;
            end else if (m_age == OPW + 1 + TIMEOUT) begin
              m_active = 2; m_prod = '0; m_to = 1'b1;
            end
          end else begin
            j = m_age - m_start_age - 1;
            m_prod[j]     = P0;
            m_prod[OPW+j] = P1;
            if (j == OPW - 1) begin m_active = 2; m_to = 1'b0; end
          end
          m_age++;
        end
        default: if (rsp_ready) begin
          m_active = 0;
          txn++;
          $display("[TB] txn %0d a=0x%h b=0x%h product=0x%h timeout=%0b", txn, m_a, m_b, m_prod, m_to);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic ea, eb;
    if (m_started && !rst) begin
      check("cyc_busy", busy, m_active != 0);
      check("cyc_req_ready", req_ready, m_active == 0);
      check("cyc_rsp_valid", rsp_valid, m_active == 2);
      if (m_active == 2) begin
        check("cyc_product", rsp_product, m_prod);
        check("cyc_timeout", rsp_timeout, m_to);
      end
      if (m_active == 0 && m_after_rst) begin
        check("cyc_rst_product", rsp_product, 0);
        check("cyc_rst_timeout", rsp_timeout, 0);
      end
      ea = 1'b0; eb = 1'b0;
      if (m_active == 1 && m_age == 1) begin
        ea = 1'b1;
      end else if (m_active == 1 && m_age >= 2 && m_age <= OPW + 1) begin
        ea = m_a[m_age-2];
        eb = m_b[m_age-2];
      end
      check("cyc_a_pad", A_PAD, ea);
      check("cyc_b_pad", B_PAD, eb);
    end
  end

  // Starts and ends on a falling edge; returns in the start-bit cycle.
  task automatic send(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    int n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    if (!req_ready) check("send_ready_bound", 0, 1);
    req_valid = 1'b1; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // lat is the cycle number after acceptance at which rsp_valid is seen.
  task automatic wait_rsp(input int start_lat, output int lat);
    lat = start_lat;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    check("rsp_wait_bound", rsp_valid, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int             lat, n, hold, r;
    logic [5:0]     sa;
    logic [PW-1:0]  held, e;
    logic [OPW-1:0] a, b;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_product", rsp_product, 0);
    check("rst_a_pad", A_PAD, 0);
    check("rst_b_pad", B_PAD, 0);
    rst = 1'b0;
    @(negedge clk);

    // 3*5, start bit two cycles into the wait window
    core_delay = 2;
    send(16'd3, 16'd5);
    sa[0] = A_PAD;
    for (int i = 1; i < 6; i++) begin @(negedge clk); sa[i] = A_PAD; end
    wait_rsp(6, lat);
    check("t1_a_pad_seq", sa, 6'b000111);
    check("t1_latency", lat, 2 * OPW + 5);
    check("t1_product", rsp_product, 32'h0000000F);
    check("t1_timeout", rsp_timeout, 0);
    take_rsp();

    // all-ones operands, minimum latency, stray P0 during the send frame
    core_delay = 0;
    send(16'hFFFF, 16'hFFFF);
    stray_p0 = 1'b1;
    repeat (10) @(negedge clk);
    stray_p0 = 1'b0;
    wait_rsp(11, lat);
    check("t2_latency", lat, 2 * OPW + 3);
    check("t2_product", rsp_product, 32'hFFFE0001);
    check("t2_high_lane", rsp_product[31:16], 16'hFFFE);
    take_rsp();

    // core never answers
    core_delay = -1;
    send(16'h1111, 16'h2222);
    wait_rsp(1, lat);
    check("t3_latency", lat, OPW + 2 + TIMEOUT);
    check("t3_timeout", rsp_timeout, 1);
    check("t3_product", rsp_product, 0);
    take_rsp();

    // start bit on the final wait cycle
    core_delay = TIMEOUT - 1;
    send(16'h00AB, 16'h0100);
    wait_rsp(1, lat);
    check("t4_latency", lat, 2 * OPW + 2 + TIMEOUT);
    check("t4_timeout", rsp_timeout, 0);
    check("t4_product", rsp_product, 32'h0000AB00);
    take_rsp();

    // backpressure with P0 noise while the result is held
    core_delay = 1;
    send(16'h0102, 16'h0304);
    wait_rsp(1, lat);
    held = rsp_product;
    for (int i = 0; i < 10; i++) begin
      stray_p0 = i[0];
      @(negedge clk);
      check("t5_hold_product", rsp_product, held);
      check("t5_hold_valid", rsp_valid, 1);
      check("t5_hold_req_ready", req_ready, 0);
    end
    stray_p0 = 1'b0;
    check("t5_product", held, 32'h00030A08);
    take_rsp();
    check("t5_idle_req_ready", req_ready, 1);
    check("t5_idle_valid", rsp_valid, 0);

    // reset during send bit 7 (cycle 9 after acceptance)
    core_delay = 0;
    send(16'hAAAA, 16'h5555);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_a_pad", A_PAD, 0);
    check("t6_b_pad", B_PAD, 0);
    check("t6_busy", busy, 0);
    check("t6_req_ready", req_ready, 1);
    check("t6_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(16'd7, 16'd9);
    wait_rsp(1, lat);
    check("t6_product", rsp_product, 32'd63);
    check("t6_timeout", rsp_timeout, 0);
    take_rsp();

    // back-to-back with req_valid held and rsp_ready tied high
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_a = 16'h1234; req_b = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    req_a = 16'h8000; req_b = 16'h8000;
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    check("t7_first_valid", rsp_valid, 1);
    check("t7_first_product", rsp_product, 32'h00002468);
    @(negedge clk);
    check("t7_gap_req_ready", req_ready, 1);
    check("t7_gap_busy", busy, 0);
    @(negedge clk);
    check("t7_second_accept", busy, 1);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    check("t7_second_valid", rsp_valid, 1);
    check("t7_second_product", rsp_product, 32'h40000000);
    @(negedge clk);
    rsp_ready = 1'b0;

    // randomized operands, response delays and backpressure
    for (int t = 0; t < 24; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      r = int'($urandom_range(0, 7));
      core_delay = (r == 0) ? -1 : ((r == 1) ? TIMEOUT - 1 : int'($urandom_range(0, TIMEOUT - 2)));
      send(a, b);
      wait_rsp(1, lat);
      e = (core_delay < 0) ? '0 : PW'(a) * PW'(b);
      check("rand_latency", lat, (core_delay < 0) ? OPW + 2 + TIMEOUT : 2 * OPW + 3 + core_delay);
      check("rand_product", rsp_product, e);
      check("rand_timeout", rsp_timeout, core_delay < 0);
      hold = int'($urandom_range(0, 3));
      repeat (hold) @(negedge clk);
      take_rsp();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
